uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Shares the single UART transmitter between two byte sources: host writes decoded by the LPC device (port A) and local echo of received UART bytes (port B). Each source is buffered in its own small FIFO. A round-robin scheduler issues one byte at a time to the transmitter and paces issues against the transmitter's `busy` handshake. The block sits between `lpc_dev`/`uart_rx` and `uart`, all on `LPC_CLK`.

## Interface
- `DEPTH`, 4, entries per source FIFO; power of two, ≥2.
- `BUSY_TIMEOUT`, 4, cycles allowed for the transmitter to raise `busy` after a strobe.

- `LPC_CLK` in 1: sole clock; all logic on the rising edge.
- `LPC_RST` in 1: reset, synchronous, active-low.
- `a_data` in 8: host byte.
- `a_valid` in 1: one-cycle strobe; push `a_data`.
- `b_data` in 8: received byte.
- `b_valid` in 1: one-cycle strobe; push `b_data` when `echo_en`=1.
- `echo_en` in 1: enables port B pushes; ignored while 0.
- `tx_data` out 8: byte to the transmitter; held stable from the strobe until the transmitter is idle again.
- `tx_valid` out 1: one-cycle issue strobe.
- `tx_busy` in 1: transmitter busy.
- `a_full` out 1: port A FIFO full.
- `a_ovf` out 1: sticky; set when a push is dropped on a full A FIFO; cleared by reset or `ovf_clr`.
- `b_ovf` out 1: same, for port B.
- `ovf_clr` in 1: clears both overflow flags.
- `idle` out 1: both FIFOs empty and FSM in IDLE.

## Operation
- FIFOs: each has separate read and write pointers of width log2(DEPTH)+1. Full is when the pointers differ only in the MSB. Empty is when the pointers are equal. Pointers wrap modulo 2·DEPTH.
- A push on a full FIFO is dropped and sets the sticky `x_ovf`. A push and a pop in the same cycle on a full FIFO: the push is dropped, because fullness is judged on the pre-edge state.
- FSM states:
  - IDLE → ISSUE when any FIFO is non-empty and `tx_busy`=0.
  - ISSUE (1 cycle) → WAIT_BUSY. In ISSUE, `tx_valid`=1 and the granted FIFO pops.
  - WAIT_BUSY → WAIT_IDLE when `tx_busy`=1, or when the timeout counter reaches BUSY_TIMEOUT. The timeout path covers a lost handshake.
  - WAIT_IDLE → IDLE when `tx_busy`=0.
- Arbitration happens in IDLE:
  - If only one FIFO is non-empty, it wins.
  - If both are non-empty, the source not granted last wins.
  - The `last` register resets to B, so A wins the first tie.
- `tx_data` is registered from the granted FIFO head on the IDLE→ISSUE edge.
- `echo_en` falling does not flush queued B bytes; they still drain.
- `ovf_clr` together with a dropped push in the same cycle: the flag ends set.

## Timing
- Reset values: `tx_data`=0x00, `tx_valid`=0, `a_ovf`=`b_ovf`=0, `a_full`=0, `idle`=1. Reset also returns the FSM to IDLE, empties both FIFOs, sets `last`=B and clears the timeout counter.
- Reset mid-transfer abandons the in-flight byte; `tx_valid` is not reasserted for it.
- Latency: push at edge N (FIFO empty, FSM IDLE, `tx_busy`=0) → `tx_valid` high during cycle N+2.
- The minimum spacing between `tx_valid` pulses is 4 cycles, set by the ISSUE, WAIT_BUSY, WAIT_IDLE and IDLE states.
- `a_full` and `idle` are combinational from registered state.
- The timeout counter resets on entry to WAIT_BUSY.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE).
  - Source enum (SRC_A, SRC_B).
  - Byte width constant (8).
- One sub-module, `byte_fifo`, instantiated twice. Parameter DEPTH; ports push, din, pop, dout, full, empty.
- Arbitration and the FSM live in `uart_tx_arb`.

## Test plan
- Single byte: reset, push A=0x41; the bench holds `tx_busy` high 10 cycles after the strobe. Required: `tx_valid` 2 cycles after the push, `tx_data`=0x41, `idle` returns to 1.
- Fairness: preload A with 0x01,0x02 and B with 0x11,0x12, `echo_en`=1. Required: issue order 0x01,0x11,0x02,0x12.
- Overflow: with `tx_busy` stuck at 1, push 5 bytes on A (DEPTH=4). Required: `a_full`=1 after the 4th push; `a_ovf`=1 after the 5th; the 5th byte is never transmitted. Then `ovf_clr` → `a_ovf`=0.
- Echo gating: `echo_en`=0, pulse `b_valid` with 0x55. Required: no push, no `tx_valid`, `b_ovf`=0.
- Lost handshake: `tx_busy` stays 0 after a strobe. Required: FSM leaves WAIT_BUSY after 4 cycles, and the next queued byte issues without deadlock.
- Reset mid-operation: assert `LPC_RST`=0 in WAIT_IDLE with 2 bytes queued. Required: the next edge gives all outputs at reset values and no further `tx_valid`.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, source ids and byte width.
package uart_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_IDLE
    } state_t;

    typedef enum logic {
        SRC_A,
        SRC_B
    } src_t;
endpackage

// File: rtl/uart_tx_arb_if.sv
// Byte-source, transmitter handshake and status signals of the UART transmit arbiter.
interface uart_tx_arb_if;
    import uart_pkg::*;

    logic [BYTE_W-1:0] a_data;
    logic              a_valid;
    logic [BYTE_W-1:0] b_data;
    logic              b_valid;
    logic              echo_en;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_busy;
    logic              a_full;
    logic              a_ovf;
    logic              b_ovf;
    logic              ovf_clr;
    logic              idle;

    modport master (
        output a_data, a_valid, b_data, b_valid, echo_en, tx_busy, ovf_clr,
        input  tx_data, tx_valid, a_full, a_ovf, b_ovf, idle
    );

    modport slave (
        input  a_data, a_valid, b_data, b_valid, echo_en, tx_busy, ovf_clr,
        output tx_data, tx_valid, a_full, a_ovf, b_ovf, idle
    );
endinterface

// File: rtl/uart_tx_arb_fifo.sv
// Small byte FIFO with extra-MSB pointers; pushes on full and pops on empty are ignored.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [BYTE_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between host writes (A) and RX echo (B).
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic          LPC_CLK,
    input  logic          LPC_RST,
    uart_tx_arb_if.slave  bus
);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    src_t              last;
    src_t              grant;
    src_t              grant_sel;
    logic [CW-1:0]     to_cnt;
    logic [CW-1:0]     to_cnt_inc;
    logic [BYTE_W-1:0] tx_data_q;
    logic              a_ovf_q;
    logic              b_ovf_q;

    logic              a_push, b_push;
    logic              a_pop, b_pop;
    logic [BYTE_W-1:0] a_dout, b_dout;
    logic              a_full, b_full;
    logic              a_empty, b_empty;

    assign a_push = bus.a_valid;
    assign b_push = bus.b_valid && bus.echo_en;
    assign a_pop  = (state == ISSUE) && (grant == SRC_A);
    assign b_pop  = (state == ISSUE) && (grant == SRC_B);

    byte_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk   (LPC_CLK),
        .rst_n (LPC_RST),
        .push  (a_push),
        .din   (bus.a_data),
        .pop   (a_pop),
        .dout  (a_dout),
        .full  (a_full),
        .empty (a_empty)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk   (LPC_CLK),
        .rst_n (LPC_RST),
        .push  (b_push),
        .din   (bus.b_data),
        .pop   (b_pop),
        .dout  (b_dout),
        .full  (b_full),
        .empty (b_empty)
    );

    assign to_cnt_inc = to_cnt + CW'(1);

    // On a tie the source that did not win last time is served.
    always_comb begin
        grant_sel = SRC_A;
        if (!a_empty && !b_empty) begin
            grant_sel = (last == SRC_B) ? SRC_A : SRC_B;
        end else if (a_empty) begin
            grant_sel = SRC_B;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((!a_empty || !b_empty) && !bus.tx_busy) state_nxt = ISSUE;
            end
            ISSUE: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Leave on the edge where the count would reach BUSY_TIMEOUT, covering a lost busy.
                if (bus.tx_busy || (to_cnt_inc == CW'(BUSY_TIMEOUT))) state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (!bus.tx_busy) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge LPC_CLK) begin
        if (!LPC_RST) begin
            state     <= IDLE;
            last      <= SRC_B;
            grant     <= SRC_A;
            to_cnt    <= '0;
            tx_data_q <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && (state_nxt == ISSUE)) begin
                grant     <= grant_sel;
                last      <= grant_sel;
                tx_data_q <= (grant_sel == SRC_A) ? a_dout : b_dout;
            end
            if (state != WAIT_BUSY) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt_inc;
            end
        end
    end

    // A dropped push in the same cycle as a clear leaves the flag set.
    always_ff @(posedge LPC_CLK) begin
        if (!LPC_RST) begin
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
        end else begin
            if (a_push && a_full)  a_ovf_q <= 1'b1;
            else if (bus.ovf_clr)  a_ovf_q <= 1'b0;
            if (b_push && b_full)  b_ovf_q <= 1'b1;
            else if (bus.ovf_clr)  b_ovf_q <= 1'b0;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = (state == ISSUE);
    assign bus.a_full   = a_full;
    assign bus.a_ovf    = a_ovf_q;
    assign bus.b_ovf    = b_ovf_q;
    assign bus.idle     = a_empty && b_empty && (state == IDLE);
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a simple transmitter model driving tx_busy.
module tb_uart_tx_arb;
    import uart_pkg::*;

    logic LPC_CLK;
    logic LPC_RST;
    uart_tx_arb_if tif ();

    uart_tx_arb #(.DEPTH(4), .BUSY_TIMEOUT(4)) dut (
        .LPC_CLK (LPC_CLK),
        .LPC_RST (LPC_RST),
        .bus     (tif.slave)
    );

    initial LPC_CLK = 1'b0;
    always #5 LPC_CLK = ~LPC_CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] iss_d[$];
    int         iss_c[$];

    logic auto_tx  = 1'b0;
    logic busy_man = 1'b0;
    int   busy_len = 3;
    int   busy_cnt = 0;

    always @(posedge LPC_CLK) cyc <= cyc + 1;

    always @(negedge LPC_CLK) begin
        if (tif.tx_valid === 1'b1) begin
            iss_d.push_back(tif.tx_data);
            iss_c.push_back(cyc);
        end
    end

    // Transmitter model: in auto mode busy follows each strobe for busy_len cycles.
    initial begin
        tif.tx_busy = 1'b0;
        forever begin
            @(posedge LPC_CLK);
            #1;
            if (auto_tx) begin
                if (tif.tx_valid === 1'b1) busy_cnt = busy_len;
                else if (busy_cnt > 0) busy_cnt--;
                tif.tx_busy = (busy_cnt > 0);
            end else begin
                busy_cnt    = 0;
                tif.tx_busy = busy_man;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge LPC_CLK);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d);
        tif.a_data  = d;
        tif.a_valid = 1'b1;
        tick(1);
        tif.a_valid = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        tif.b_data  = d;
        tif.b_valid = 1'b1;
        tick(1);
        tif.b_valid = 1'b0;
    endtask

    task automatic push_ab(input logic [7:0] da, input logic [7:0] db);
        tif.a_data  = da;
        tif.b_data  = db;
        tif.a_valid = 1'b1;
        tif.b_valid = 1'b1;
        tick(1);
        tif.a_valid = 1'b0;
        tif.b_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        tif.a_valid = 1'b0;
        tif.b_valid = 1'b0;
        tif.ovf_clr = 1'b0;
        tif.echo_en = 1'b0;
        auto_tx     = 1'b0;
        busy_man    = 1'b0;
        LPC_RST     = 1'b0;
        tick(2);
        check({tag, "_rst_txd"},   32'(tif.tx_data),  32'h00);
        check({tag, "_rst_txv"},   32'(tif.tx_valid), 32'h0);
        check({tag, "_rst_ovf"},   32'({tif.a_ovf, tif.b_ovf}), 32'h0);
        check({tag, "_rst_afull"}, 32'(tif.a_full),   32'h0);
        check({tag, "_rst_idle"},  32'(tif.idle),     32'h1);
        LPC_RST = 1'b1;
        tick(1);
        iss_d.delete();
        iss_c.delete();
    endtask

    task automatic wait_issues(input string tag, input int n, input int budget);
        int k = 0;
        while (iss_d.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_issue_cnt"}, 32'(iss_d.size()), 32'(n));
    endtask

    initial begin
        int push_cyc;
        int k;
        logic [7:0] exp_fair [4] = '{8'h01, 8'h11, 8'h02, 8'h12};

        tif.a_data = 8'h00;
        tif.b_data = 8'h00;

        // Single byte with a 10-cycle busy from the transmitter.
        do_reset("single");
        auto_tx  = 1'b1;
        busy_len = 10;
        push_cyc = cyc;
        push_a(8'h41);
        check("single_txv_early", 32'(tif.tx_valid), 32'h0);
        check("single_busy_idle", 32'(tif.idle),     32'h0);
        tick(1);
        check("single_txv",  32'(tif.tx_valid), 32'h1);
        check("single_txd",  32'(tif.tx_data),  32'h41);
        tick(9);
        check("single_idle_held", 32'(tif.idle), 32'h0);
        k = 0;
        while (tif.idle !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("single_idle_back", 32'(tif.idle),    32'h1);
        check("single_txd_held",  32'(tif.tx_data), 32'h41);
        check("single_cnt",       32'(iss_d.size()), 32'd1);
        if (iss_c.size() == 1) check("single_latency", 32'(iss_c[0] - push_cyc), 32'd2);

        // Fairness with both FIFOs preloaded.
        do_reset("fair");
        busy_man = 1'b1;
        tif.echo_en = 1'b1;
        tick(2);
        push_ab(8'h01, 8'h11);
        push_ab(8'h02, 8'h12);
        check("fair_held", 32'(iss_d.size()), 32'd0);
        busy_len = 3;
        auto_tx  = 1'b1;
        wait_issues("fair", 4, 120);
        for (int i = 0; i < 4; i++) begin
            if (i < iss_d.size()) check($sformatf("fair_ord%0d", i), 32'(iss_d[i]), 32'(exp_fair[i]));
        end
        for (int i = 1; i < iss_c.size(); i++) begin
            check($sformatf("fair_space%0d", i), 32'(iss_c[i] - iss_c[i-1] >= 4), 32'h1);
        end

        // Overflow on A with the transmitter stuck busy.
        do_reset("ovf");
        busy_man = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) push_a(8'hA0 + 8'(i));
        check("ovf_full4",  32'(tif.a_full), 32'h1);
        check("ovf_notyet", 32'(tif.a_ovf),  32'h0);
        push_a(8'hA4);
        check("ovf_set",    32'(tif.a_ovf),  32'h1);
        check("ovf_bclean", 32'(tif.b_ovf),  32'h0);
        tif.ovf_clr = 1'b1;
        tick(1);
        tif.ovf_clr = 1'b0;
        check("ovf_clr", 32'(tif.a_ovf), 32'h0);
        tif.a_data  = 8'hEE;
        tif.a_valid = 1'b1;
        tif.ovf_clr = 1'b1;
        tick(1);
        tif.a_valid = 1'b0;
        tif.ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(tif.a_ovf), 32'h1);
        check("ovf_no_issue", 32'(iss_d.size()), 32'd0);
        busy_len = 3;
        auto_tx  = 1'b1;
        wait_issues("ovf", 4, 120);
        for (int i = 0; i < 4; i++) begin
            if (i < iss_d.size()) check($sformatf("ovf_ord%0d", i), 32'(iss_d[i]), 32'hA0 + 32'(i));
        end
        tick(20);
        check("ovf_5th_dropped", 32'(iss_d.size()), 32'd4);
        check("ovf_idle",        32'(tif.idle),     32'h1);

        // Echo gating, then B overflow and drain after echo_en falls.
        do_reset("echo");
        push_b(8'h55);
        tick(10);
        check("echo_gate_cnt",  32'(iss_d.size()), 32'd0);
        check("echo_gate_idle", 32'(tif.idle),     32'h1);
        check("echo_gate_ovf",  32'(tif.b_ovf),    32'h0);
        busy_man = 1'b1;
        tick(2);
        tif.echo_en = 1'b1;
        for (int i = 0; i < 5; i++) push_b(8'h60 + 8'(i));
        check("echo_bovf", 32'(tif.b_ovf), 32'h1);
        check("echo_aovf", 32'(tif.a_ovf), 32'h0);
        tif.echo_en = 1'b0;
        busy_len = 3;
        auto_tx  = 1'b1;
        wait_issues("echo", 4, 120);
        for (int i = 0; i < 4; i++) begin
            if (i < iss_d.size()) check($sformatf("echo_ord%0d", i), 32'(iss_d[i]), 32'h60 + 32'(i));
        end

        // Lost handshake: busy never rises, timeout must keep bytes flowing.
        do_reset("lost");
        push_cyc = cyc;
        push_a(8'h71);
        push_a(8'h72);
        wait_issues("lost", 2, 60);
        if (iss_d.size() == 2) begin
            check("lost_d0",    32'(iss_d[0]), 32'h71);
            check("lost_d1",    32'(iss_d[1]), 32'h72);
            check("lost_lat",   32'(iss_c[0] - push_cyc), 32'd2);
            check("lost_space", 32'(iss_c[1] - iss_c[0]), 32'd7);
        end

        // Reset while waiting for the transmitter to go idle with two bytes queued.
        do_reset("midrst");
        busy_len = 6;
        auto_tx  = 1'b1;
        push_a(8'h81);
        push_a(8'h82);
        push_a(8'h83);
        tick(1);
        check("midrst_pre_idle", 32'(tif.idle),     32'h0);
        check("midrst_pre_cnt",  32'(iss_d.size()), 32'd1);
        LPC_RST = 1'b0;
        tick(1);
        check("midrst_txd",  32'(tif.tx_data),  32'h00);
        check("midrst_txv",  32'(tif.tx_valid), 32'h0);
        check("midrst_full", 32'(tif.a_full),   32'h0);
        check("midrst_ovf",  32'({tif.a_ovf, tif.b_ovf}), 32'h0);
        check("midrst_idle", 32'(tif.idle),     32'h1);
        LPC_RST = 1'b1;
        tick(20);
        check("midrst_no_more", 32'(iss_d.size()), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end
endmodule
